// File: rtl/elixirchip_es1_spu_op_accsu.sv
`default_nettype none
// ============================================================================
// Module   : elixirchip_es1_spu_op_accsu
// Purpose  : signed product accumulator with arithmetic shift and saturating
//            or wrapping output narrowing, for MAC chains behind the multiplier
// Revision : 1.0 - initial release
// ============================================================================
module elixirchip_es1_spu_op_accsu #(
    parameter int    LATENCY     = 2,
    parameter int    S_DATA_BITS = 16,
    parameter int    ACC_BITS    = 32,
    parameter int    M_DATA_BITS = 16,
    parameter int    DATA_SHIFT  = 0,
    parameter int    SATURATE    = 1,
    parameter string DEVICE      = "RTL",
    parameter string SIMULATION  = "false",
    parameter string DEBUG       = "false"
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cke,
    input  logic signed [S_DATA_BITS-1:0] s_data,
    input  logic                          s_clear,
    input  logic                          s_valid,
    output logic signed [M_DATA_BITS-1:0] m_data,
    output logic                          m_overflow
);

    localparam logic signed [ACC_BITS-1:0]    c_acc_max = {1'b0, {(ACC_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0]    c_acc_min = {1'b1, {(ACC_BITS-1){1'b0}}};
    localparam logic signed [M_DATA_BITS-1:0] c_m_max   = {1'b0, {(M_DATA_BITS-1){1'b1}}};
    localparam logic signed [M_DATA_BITS-1:0] c_m_min   = {1'b1, {(M_DATA_BITS-1){1'b0}}};

    generate
        if (LATENCY < 2 || ACC_BITS < S_DATA_BITS || DEVICE == ""
            || (SIMULATION != "true" && SIMULATION != "false")
            || (DEBUG != "true" && DEBUG != "false")) begin : g_param_check
            $error("elixirchip_es1_spu_op_accsu: illegal parameter combination");
        end
    endgenerate

    // Stage 0 state
    logic signed [ACC_BITS-1:0]    r_acc;
    logic                          r_ovf;
    // r_vld[k] qualifies the value feeding pipeline stage k+1
    logic        [LATENCY-2:0]     r_vld;
    logic signed [M_DATA_BITS-1:0] r_pipe_data [1:LATENCY-1];
    logic                          r_pipe_ovf  [1:LATENCY-1];

    logic signed [ACC_BITS-1:0]    w_s_ext;
    logic signed [ACC_BITS:0]      w_sum;
    logic                          w_sum_ovf;
    logic signed [ACC_BITS-1:0]    w_acc_next;
    logic signed [ACC_BITS-1:0]    w_shift;
    logic signed [M_DATA_BITS-1:0] w_narrow;
    logic                          w_narrow_ovf;

    assign w_s_ext   = ACC_BITS'(s_data);
    // One guard bit: overflow shows as disagreement of the top two sum bits
    assign w_sum     = (ACC_BITS+1)'(r_acc) + (ACC_BITS+1)'(w_s_ext);
    assign w_sum_ovf = w_sum[ACC_BITS] ^ w_sum[ACC_BITS-1];

    always_comb begin
        w_acc_next = w_sum[ACC_BITS-1:0];
        if (w_sum_ovf && SATURATE != 0) begin
            w_acc_next = w_sum[ACC_BITS] ? c_acc_min : c_acc_max;
        end
    end

    assign w_shift = r_acc >>> DATA_SHIFT;

    generate
        if (ACC_BITS > M_DATA_BITS) begin : g_narrow
            // Fits when every bit above the output sign bit repeats it
            logic [ACC_BITS-M_DATA_BITS:0] w_top;
            assign w_top        = w_shift[ACC_BITS-1:M_DATA_BITS-1];
            assign w_narrow_ovf = !((&w_top) || !(|w_top));
            always_comb begin
                w_narrow = w_shift[M_DATA_BITS-1:0];
                if (w_narrow_ovf && SATURATE != 0) begin
                    w_narrow = w_shift[ACC_BITS-1] ? c_m_min : c_m_max;
                end
            end
        end else begin : g_widen
            assign w_narrow     = M_DATA_BITS'(w_shift);
            assign w_narrow_ovf = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_vld <= '0;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe_data[i] <= '0;
                r_pipe_ovf[i]  <= 1'b0;
            end
        end else if (cke) begin
            r_vld[0] <= s_valid;
            for (int i = 1; i <= LATENCY-2; i++) begin
                r_vld[i] <= r_vld[i-1];
            end

            if (s_valid) begin
                if (s_clear) begin
                    r_acc <= w_s_ext;
                    r_ovf <= 1'b0;
                end else begin
                    r_acc <= w_acc_next;
                    r_ovf <= r_ovf | w_sum_ovf;
                end
            end

            if (r_vld[0]) begin
                r_pipe_data[1] <= w_narrow;
                r_pipe_ovf[1]  <= r_ovf | w_narrow_ovf;
            end

            // Extra delay stages advance only with their own valid
            for (int i = 2; i < LATENCY; i++) begin
                if (r_vld[i-1]) begin
                    r_pipe_data[i] <= r_pipe_data[i-1];
                    r_pipe_ovf[i]  <= r_pipe_ovf[i-1];
                end
            end
        end
    end

    assign m_data     = r_pipe_data[LATENCY-1];
    assign m_overflow = r_pipe_ovf[LATENCY-1];

endmodule
`default_nettype wire

// File: doc/elixirchip_es1_spu_op_accsu.md
Name: elixirchip_es1_spu_op_accsu

Overview:
- Signed accumulate stage placed directly downstream of the signed×unsigned multiplier op; consumes its product stream and sums successive products into a wide accumulator.
- s_clear marks the first product of a new sum; output is optionally right-shifted and saturated to M_DATA_BITS.
- Builds MAC chains in the SPU, e.g. FIR taps or dot products.

Parameters:
- LATENCY, 2, s_valid-to-m_data latency in cycles; minimum 2; extra cycles are pure delay.
- S_DATA_BITS, 16, signed input width (multiplier product width).
- ACC_BITS, 32, signed accumulator width; must satisfy ACC_BITS >= S_DATA_BITS.
- M_DATA_BITS, 16, signed output width.
- DATA_SHIFT, 0, arithmetic right shift applied to the accumulator before output narrowing.
- SATURATE, 1, 1 = saturate on accumulator and output overflow; 0 = two's-complement wrap.
- DEVICE, "RTL", target device name.
- SIMULATION, "false", simulation switch.
- DEBUG, "false", debug switch.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous reset, active-low (0 = reset)
- cke  input  1  clock enable
- s_data  input  S_DATA_BITS  signed product to accumulate
- s_clear  input  1  start a new sum: load s_data instead of adding it
- s_valid  input  1  s_data/s_clear are valid this cycle
- m_data  output  M_DATA_BITS  signed accumulated result
- m_overflow  output  1  sticky flag: saturation or wrap occurred since the last s_clear

Behaviour:
- Reset
  - On a clk edge with reset==0, every register is set to 0: accumulator, valid pipeline, m_data, m_overflow.
  - Reset has priority over cke.
  - Reset mid-sum discards the partial sum; the next non-clear valid input adds to 0.
- cke
  - cke==0 freezes every register, including the delay line.
  - Only cycles with cke==1 count toward latency.
- Stage 0 (accumulate), when s_valid==1 and cke==1:
  - s_clear==1: acc <= sign-extended s_data; ovf <= 0.
  - s_clear==0: sum = acc + sext(s_data), computed at ACC_BITS+1 bits.
  - If sum exceeds the ACC_BITS range: with SATURATE=1, acc <= ACC max or min (by sign); with SATURATE=0, acc <= the low ACC_BITS bits. In both cases ovf <= 1.
  - s_valid==0: acc and ovf hold; s_clear is ignored.
- Stage 1 (output), when stage-0 valid==1:
  - t = acc >>> DATA_SHIFT (arithmetic shift).
  - If t fits in M_DATA_BITS signed: m_data <= t.
  - Otherwise: SATURATE=1 gives M max or min; SATURATE=0 gives the low bits. Either way m_overflow <= 1 (sticky with ovf).
  - m_overflow is the stage-0 ovf OR'ed with the stage-1 narrowing overflow.
  - When stage-0 valid==0, m_data and m_overflow hold.
- Latency
  - A valid input at cke-cycle n appears on m_data after cke-cycle n+LATENCY.
  - LATENCY>2 adds LATENCY-2 register stages on m_data, m_overflow and valid; these stages load only when their valid is set, otherwise they hold.
- Back-to-back: consecutive valid inputs at full rate are supported; acc feeds back in a single cycle with no bubbles.
- s_clear with s_valid==1 on two consecutive cycles: each cycle starts a new sum, so the output is the raw s_data each time.
- Width rules
  - All arithmetic is signed.
  - s_data is sign-extended to ACC_BITS.
  - Saturation limits: ±(2^(W-1)) boundaries, i.e. max = 2^(W-1)-1, min = -2^(W-1).

Test Plan:
- Reset=0 for 3 cycles, then release (defaults, LATENCY=2) -> m_data=0, m_overflow=0.
- Valid sequence {clear:5, 7, -3}, one per cycle -> m_data shows 5, 12, 9 on successive cycles, starting 2 cycles after the first input; m_overflow=0.
- ACC_BITS=16, S_DATA_BITS=16, SATURATE=1; inputs clear:30000 then 10000 -> acc saturates to 32767, m_overflow=1; next clear:1 -> m_data=1, m_overflow=0.
- Same setup with SATURATE=0 -> 30000+10000 wraps to -25536, m_overflow=1.
- M_DATA_BITS=8, DATA_SHIFT=2, SATURATE=1; input clear:1000 -> t=250, so m_data=127, m_overflow=1. Input clear:-12 -> m_data=-3, m_overflow=0.
- LATENCY=4, cke toggled 1,0,1,0 during a 3-input sum with s_valid gaps -> result appears after 4 enabled cycles, equal to the cke-always-high result. Reset=0 asserted mid-sum -> outputs 0, and the next unflagged input 4 -> m_data=4.
